pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register; one instance per boundary (D/E, E/M, M/W).
- Carries a valid bit, register-write control, destination register, Tnew hazard counter, instruction word and NUM_CH data channels such as PC, PC8, ALU result and memory data.
- Adds stall (hold), flush (bubble insertion), stage-local Tnew decrement, a forwarding-ready flag and a saturating bubble counter for the hazard unit and the testbench.

---
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush control, saturating Tnew
// decrement, a forwarding-ready flag and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 4,
    parameter int TNEW_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     valid_in,
    input  logic                     regwrite_in,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [4:0]               dst_in,
    input  logic [TNEW_W-1:0]        tnew_in,
    input  logic [DATA_W-1:0]        instr_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic                     valid_out,
    output logic                     regwrite_out,
    output logic [SEL_W-1:0]         sel_out,
    output logic [4:0]               dst_out,
    output logic [TNEW_W-1:0]        tnew_out,
    output logic [DATA_W-1:0]        instr_out,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     fwd_ok,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              valid_reg;
    logic              regwrite_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [4:0]        dst_reg;
    logic [TNEW_W-1:0] tnew_reg;
    logic [TNEW_W-1:0] tnew_next;
    logic [DATA_W-1:0] instr_reg;
    logic [CNT_W-1:0]  bubble_cnt_reg;
    logic              bubble_event;
    logic              data_load;

    // Tnew counts down by one per stage but never wraps below zero.
    assign tnew_next    = (tnew_in == '0) ? '0 : tnew_in - TNEW_W'(1);
    assign bubble_event = flush | (~stall & ~valid_in);
    assign data_load    = flush | ~stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            sel_reg      <= '0;
            dst_reg      <= '0;
            tnew_reg     <= '0;
            instr_reg    <= '0;
        end else if (flush) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            sel_reg      <= '0;
            dst_reg      <= '0;
            tnew_reg     <= '0;
            instr_reg    <= '0;
        end else if (!stall) begin
            valid_reg    <= valid_in;
            regwrite_reg <= regwrite_in & valid_in;
            sel_reg      <= sel_in;
            dst_reg      <= dst_in;
            tnew_reg     <= tnew_next;
            instr_reg    <= instr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_cnt_reg <= '0;
        end else if (bubble_event && bubble_cnt_reg != CNT_MAX) begin
            bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
        end
    end

    // Data channels still load on a flush so the PC survives for debug.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] ch_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    ch_reg <= '0;
                end else if (data_load) begin
                    ch_reg <= data_in[gi*DATA_W +: DATA_W];
                end
            end

            assign data_out[gi*DATA_W +: DATA_W] = ch_reg;
        end
    endgenerate

    assign valid_out    = valid_reg;
    assign regwrite_out = regwrite_reg;
    assign sel_out      = sel_reg;
    assign dst_out      = dst_reg;
    assign tnew_out     = tnew_reg;
    assign instr_out    = instr_reg;
    assign bubble_cnt   = bubble_cnt_reg;
    assign fwd_ok       = valid_reg & regwrite_reg & (dst_reg != 5'd0) & (tnew_reg == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: table of single-cycle vectors on a
// default instance plus hand sequences on a narrow, small-counter instance.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (defaults)
    logic         reset, stall, flush, valid_in, regwrite_in;
    logic [3:0]   sel_in;
    logic [4:0]   dst_in;
    logic [1:0]   tnew_in;
    logic [31:0]  instr_in;
    logic [127:0] data_in;
    logic         valid_out, regwrite_out, fwd_ok;
    logic [3:0]   sel_out;
    logic [4:0]   dst_out;
    logic [1:0]   tnew_out;
    logic [31:0]  instr_out;
    logic [127:0] data_out;
    logic [15:0]  bubble_cnt;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .regwrite_in(regwrite_in), .sel_in(sel_in),
        .dst_in(dst_in), .tnew_in(tnew_in), .instr_in(instr_in), .data_in(data_in),
        .valid_out(valid_out), .regwrite_out(regwrite_out), .sel_out(sel_out),
        .dst_out(dst_out), .tnew_out(tnew_out), .instr_out(instr_out),
        .data_out(data_out), .fwd_ok(fwd_ok), .bubble_cnt(bubble_cnt)
    );

    // Narrow instance: two 16-bit channels, 3-bit bubble counter
    logic        b_reset, b_stall, b_flush, b_valid_in, b_regwrite_in;
    logic [3:0]  b_sel_in;
    logic [4:0]  b_dst_in;
    logic [1:0]  b_tnew_in;
    logic [15:0] b_instr_in;
    logic [31:0] b_data_in;
    logic        b_valid_out, b_regwrite_out, b_fwd_ok;
    logic [3:0]  b_sel_out;
    logic [4:0]  b_dst_out;
    logic [1:0]  b_tnew_out;
    logic [15:0] b_instr_out;
    logic [31:0] b_data_out;
    logic [2:0]  b_bubble_cnt;

    pipe_stage_reg #(.DATA_W(16), .NUM_CH(2), .CNT_W(3)) dut_b (
        .clk(clk), .reset(b_reset), .stall(b_stall), .flush(b_flush),
        .valid_in(b_valid_in), .regwrite_in(b_regwrite_in), .sel_in(b_sel_in),
        .dst_in(b_dst_in), .tnew_in(b_tnew_in), .instr_in(b_instr_in), .data_in(b_data_in),
        .valid_out(b_valid_out), .regwrite_out(b_regwrite_out), .sel_out(b_sel_out),
        .dst_out(b_dst_out), .tnew_out(b_tnew_out), .instr_out(b_instr_out),
        .data_out(b_data_out), .fwd_ok(b_fwd_ok), .bubble_cnt(b_bubble_cnt)
    );

    typedef struct packed {
        logic        rst_n, st, fl, v, rw;
        logic [3:0]  sel;
        logic [4:0]  dst;
        logic [1:0]  tn;
        logic [31:0] instr, ch0;
        logic        e_v, e_rw;
        logic [3:0]  e_sel;
        logic [4:0]  e_dst;
        logic [1:0]  e_tn;
        logic [31:0] e_instr, e_ch0;
        logic        e_fwd;
        logic [15:0] e_bc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst st fl v rw sel dst tn instr ch0 | v rw sel dst tn instr ch0 fwd bc
        vecs[0]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,4'hf,5'd31,2'd3,32'hffffffff,32'hffffffff, 1'b0,1'b0,4'h0,5'd0,2'd0,32'h0,32'h0,1'b0,16'd0};
        vecs[1]  = vecs[0];
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,4'h3,5'd8,2'd2,32'h3c081234,32'h3000, 1'b1,1'b1,4'h3,5'd8,2'd1,32'h3c081234,32'h3000,1'b0,16'd0};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,4'h9,5'd9,2'd3,32'hdeadbeef,32'hdead, 1'b1,1'b1,4'h3,5'd8,2'd1,32'h3c081234,32'h3000,1'b0,16'd0};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,4'ha,5'd10,2'd0,32'h0badf00d,32'hbeef, 1'b1,1'b1,4'h3,5'd8,2'd1,32'h3c081234,32'h3000,1'b0,16'd0};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,4'hb,5'd11,2'd2,32'h12345678,32'hcafe, 1'b1,1'b1,4'h3,5'd8,2'd1,32'h3c081234,32'h3000,1'b0,16'd0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,4'h1,5'd8,2'd0,32'h11,32'h3004, 1'b1,1'b1,4'h1,5'd8,2'd0,32'h11,32'h3004,1'b1,16'd0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,4'h1,5'd0,2'd0,32'h11,32'h3004, 1'b1,1'b1,4'h1,5'd0,2'd0,32'h11,32'h3004,1'b0,16'd0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,4'h1,5'd8,2'd0,32'h12,32'h3004, 1'b1,1'b0,4'h1,5'd8,2'd0,32'h12,32'h3004,1'b0,16'd0};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,4'h2,5'd4,2'd2,32'haa,32'h100, 1'b0,1'b0,4'h2,5'd4,2'd1,32'haa,32'h100,1'b0,16'd1};
        vecs[10] = '{1'b1,1'b1,1'b1,1'b1,1'b1,4'h7,5'd5,2'd2,32'h1234,32'h3008, 1'b0,1'b0,4'h0,5'd0,2'd0,32'h0,32'h3008,1'b0,16'd2};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b1,1'b1,4'h5,5'd3,2'd3,32'h21,32'h300c, 1'b1,1'b1,4'h5,5'd3,2'd2,32'h21,32'h300c,1'b0,16'd2};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b1,1'b1,4'h5,5'd3,2'd1,32'h22,32'h3010, 1'b1,1'b1,4'h5,5'd3,2'd0,32'h22,32'h3010,1'b1,16'd2};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h2,5'd4,2'd2,32'hab,32'h101, 1'b0,1'b0,4'h2,5'd4,2'd1,32'hab,32'h101,1'b0,16'd3};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h2,5'd4,2'd2,32'hac,32'h102, 1'b0,1'b0,4'h2,5'd4,2'd1,32'hac,32'h102,1'b0,16'd4};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h2,5'd4,2'd2,32'had,32'h103, 1'b0,1'b0,4'h2,5'd4,2'd1,32'had,32'h103,1'b0,16'd5};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h2,5'd4,2'd2,32'hae,32'h104, 1'b0,1'b0,4'h2,5'd4,2'd1,32'hae,32'h104,1'b0,16'd6};
        vecs[17] = '{1'b1,1'b0,1'b1,1'b0,1'b0,4'h2,5'd4,2'd2,32'haf,32'h200, 1'b0,1'b0,4'h0,5'd0,2'd0,32'h0,32'h200,1'b0,16'd7};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b1,1'b1,4'h6,5'd8,2'd0,32'h33,32'h3014, 1'b1,1'b1,4'h6,5'd8,2'd0,32'h33,32'h3014,1'b1,16'd7};
        vecs[19] = '{1'b0,1'b1,1'b0,1'b1,1'b1,4'h6,5'd9,2'd3,32'h44,32'h3018, 1'b0,1'b0,4'h0,5'd0,2'd0,32'h0,32'h0,1'b0,16'd0};

        b_reset = 1'b0; b_stall = 1'b0; b_flush = 1'b0; b_valid_in = 1'b0;
        b_regwrite_in = 1'b0; b_sel_in = '0; b_dst_in = '0; b_tnew_in = '0;
        b_instr_in = '0; b_data_in = '0;

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst_n; stall = vecs[i].st; flush = vecs[i].fl;
            valid_in = vecs[i].v; regwrite_in = vecs[i].rw; sel_in = vecs[i].sel;
            dst_in = vecs[i].dst; tnew_in = vecs[i].tn; instr_in = vecs[i].instr;
            data_in = {vecs[i].ch0 + 32'd3, vecs[i].ch0 + 32'd2, vecs[i].ch0 + 32'd1, vecs[i].ch0};
            tick();
            chk("valid_out", i, 64'(valid_out), 64'(vecs[i].e_v));
            chk("regwrite_out", i, 64'(regwrite_out), 64'(vecs[i].e_rw));
            chk("sel_out", i, 64'(sel_out), 64'(vecs[i].e_sel));
            chk("dst_out", i, 64'(dst_out), 64'(vecs[i].e_dst));
            chk("tnew_out", i, 64'(tnew_out), 64'(vecs[i].e_tn));
            chk("instr_out", i, 64'(instr_out), 64'(vecs[i].e_instr));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("data_ch%0d", k), i, 64'(data_out[k*32 +: 32]),
                    64'((vecs[i].e_ch0 == 32'd0) ? 32'd0 : vecs[i].e_ch0 + 32'(k)));
            end
            chk("fwd_ok", i, 64'(fwd_ok), 64'(vecs[i].e_fwd));
            chk("bubble_cnt", i, 64'(bubble_cnt), 64'(vecs[i].e_bc));
            $display("vec %0d: v=%0b rw=%0b dst=%0d tnew=%0d ch0=%0h fwd=%0b bcnt=%0d",
                     i, valid_out, regwrite_out, dst_out, tnew_out, data_out[31:0], fwd_ok, bubble_cnt);
        end

        // Reset while a flush is requested: reset wins.
        reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b1; data_in = 128'h55;
        tick();
        reset = 1'b0; flush = 1'b1;
        tick();
        chk("rst_flush_valid", 0, 64'(valid_out), 64'd0);
        chk("rst_flush_data", 0, 64'(data_out[63:0]), 64'd0);
        chk("rst_flush_bcnt", 0, 64'(bubble_cnt), 64'd0);
        $display("reset-over-flush: v=%0b data=%0h bcnt=%0d", valid_out, data_out[63:0], bubble_cnt);

        // Narrow instance: channel slicing and 3-bit counter saturation.
        tick();
        b_reset = 1'b1; b_valid_in = 1'b1; b_regwrite_in = 1'b1; b_dst_in = 5'd7;
        b_tnew_in = 2'd1; b_instr_in = 16'h5a5a; b_data_in = {16'hbeef, 16'h1234};
        tick();
        chk("b_ch0", 0, 64'(b_data_out[15:0]), 64'h1234);
        chk("b_ch1", 0, 64'(b_data_out[31:16]), 64'hbeef);
        chk("b_instr", 0, 64'(b_instr_out), 64'h5a5a);
        chk("b_fwd_ok", 0, 64'(b_fwd_ok), 64'd1);
        $display("narrow load: ch1=%0h ch0=%0h instr=%0h fwd=%0b",
                 b_data_out[31:16], b_data_out[15:0], b_instr_out, b_fwd_ok);
        for (int n = 1; n <= 10; n++) begin
            b_valid_in = 1'b0;
            b_flush = (n % 3 == 0);
            b_data_in = {16'(n), 16'(n + 100)};
            tick();
            chk("b_bubble_cnt", n, 64'(b_bubble_cnt), 64'((n > 7) ? 7 : n));
            $display("narrow bubble %0d: bcnt=%0d ch0=%0h", n, b_bubble_cnt, b_data_out[15:0]);
        end
        chk("b_ch0_last", 0, 64'(b_data_out[15:0]), 64'd110);
        chk("b_ch1_last", 0, 64'(b_data_out[31:16]), 64'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
